freq_meter_ctrl: RTL
====================

Name: freq_meter_ctrl

Overview:
Measurement sequencer for the 4-digit BCD counter (cont_BCD) in the frequency-meter datapath. Runs on the reference clock and drives the counter's clear (limp) and enable (hab) inputs. Each cycle is clear → fixed gate window → settle → latch. The latched BCD result and status flags go to the display path.

Parameters:
GATE_CYCLES, 1000, length of the hab window in clk cycles (1 s at 1 kHz reference); legal range 1..2^20-1.
CLR_CYCLES, 2, length of the limp pulse in clk cycles; legal range 1..15.
SETTLE_CYCLES, 4, wait after hab falls before sampling the counter, covering clk_amostra→clk crossing; legal range 1..15.

Ports:
clk  in  1  reference clock; all logic on posedge.
RESET  in  1  reset, synchronous, active-high.
start  in  1  level; requests one measurement when idle.
auto_run  in  1  1 = re-arm automatically after each latch.
cont_3..cont_0  in  4 each  BCD digits from the counter (thousands..units).
limp  out  1  counter clear.
hab  out  1  counter enable (gate).
busy  out  1  high whenever state ≠ IDLE.
disp_3..disp_0  out  4 each  latched BCD result.
meas_valid  out  1  one-cycle pulse when disp_* updates.
ovf  out  1  latched result = 9999 (counter saturated or wrapped; reading untrustworthy).
bcd_err  out  1  any sampled digit > 9.

Behaviour:
- All outputs are registered. On RESET (sync, any state, including mid-gate): state = IDLE. Gate/phase counter = 0. limp, hab, busy, meas_valid, ovf, bcd_err = 0. disp_* = 0.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH. One down-counting phase timer is shared by CLEAR, GATE and SETTLE.
- IDLE: limp = hab = 0. Leave when (start | auto_run) = 1 at an edge; load the timer with CLR_CYCLES-1 and go to CLEAR.
- CLEAR: limp = 1. At timer = 0, load GATE_CYCLES-1 and go to GATE.
- GATE: hab = 1. At timer = 0, load SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: hab = limp = 0. At timer = 0, go to LATCH.
- LATCH, one cycle:
  - disp_* ← cont_*.
  - ovf ← all four digits = 9.
  - bcd_err ← any digit > 9.
  - meas_valid = 1.
  - Next state: CLEAR (timer reload) if auto_run = 1, else IDLE.
- Cycle timing: start sampled high at edge t0 →
  - limp high for cycles t0+1 .. t0+CLR_CYCLES;
  - hab high for exactly GATE_CYCLES cycles starting at t0+CLR_CYCLES+1;
  - meas_valid at t0+CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1.
  - Defaults: limp cycles 1–2, hab cycles 3–1002, meas_valid cycle 1007.
- limp and hab are never high in the same cycle. hab never toggles inside a window.
- start or auto_run changes while busy are ignored. Dropping auto_run mid-measurement lets the current measurement finish, then returns to IDLE. A measurement is never aborted except by RESET.
- Back-to-back under auto_run: LATCH → CLEAR with no IDLE cycle. Period = CLR+GATE+SETTLE+1 cycles.
- disp_*, ovf and bcd_err hold their values between LATCH cycles. They are not cleared by entering CLEAR.
- The timer width is sized from GATE_CYCLES via $clog2. No wrap is permitted; the timer counts down only while in CLEAR, GATE or SETTLE.

Decomposition:
- Package freq_meter_pkg:
  - typedef bcd_digit_t (logic [3:0]);
  - enum meas_state_t {IDLE, CLEAR, GATE, SETTLE, LATCH};
  - constants BCD_MAX = 9, BCD_FULL = 9999.
- Sub-module phase_timer: loadable down-counter with load, load_val, en and a zero flag; instantiated once.

Test Plan:
- Reset/idle: RESET high 3 cycles, then start = 0, auto_run = 0 → all outputs 0, busy = 0 for 50 cycles.
- Single shot: GATE_CYCLES=10, CLR=2, SETTLE=4. start pulse at t0; counter model counts clk_amostra at 3× clk → limp at t0+1..2, hab t0+3..12, meas_valid t0+17 only, disp = 0,0,3,0, ovf = 0.
- Auto-run: auto_run = 1 held, same params → meas_valid every 17 cycles. Drop auto_run after the 2nd pulse → 3rd pulse still occurs, then busy = 0.
- Overflow/error: force cont = 9,9,9,9 at LATCH → ovf = 1. Next measurement with cont_0 = 4'hC → bcd_err = 1, ovf = 0.
- Reset mid-gate: assert RESET at t0+6 (hab high) → next cycle hab = 0, busy = 0, disp = 0, no meas_valid.
- Start while busy: pulse start at t0+5 during an active measurement → exactly one meas_valid; hab width stays 10.

Source files
------------

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared types and constants for the frequency-meter
//               measurement sequencer (BCD digit type, sequencer states,
//               BCD limits, digit validity helper).
// Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4
    } meas_state_t;

    // Largest legal BCD digit.
    localparam bcd_digit_t  BCD_MAX  = 4'd9;
    // 9999 as four packed BCD digits: the saturated counter reading.
    localparam logic [15:0] BCD_FULL = 16'h9999;

    // A nibble above 9 is not a BCD digit.
    function automatic logic digit_bad(input bcd_digit_t d);
        return (d > BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter shared by the timed sequencer phases.
//               Load has priority over counting; counting stops at zero so
//               the value never wraps.
// Ports       : clk, RESET (sync, active-high)
//               load     - load load_val this cycle
//               load_val - value to load
//               en       - count down by one when nonzero
//               zero     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/freq_meter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_ctrl
// Description : Measurement sequencer for the 4-digit BCD counter. Each
//               measurement is clear -> gate window -> settle -> latch.
//               All outputs are registered from the current state, so every
//               output appears one cycle after the state it belongs to.
// Ports       : clk, RESET (sync, active-high)
//               start       - level, requests one measurement when idle
//               auto_run    - re-arm automatically after each latch
//               cont_3..0   - BCD digits from the counter
//               limp / hab  - counter clear / counter enable
//               busy        - sequencer not idle
//               disp_3..0   - latched BCD result
//               meas_valid  - one-cycle pulse when disp_* updates
//               ovf         - latched result is 9999
//               bcd_err     - a latched digit was not BCD
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter_ctrl
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = 1000,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       start,
    input  logic       auto_run,
    input  bcd_digit_t cont_3,
    input  bcd_digit_t cont_2,
    input  bcd_digit_t cont_1,
    input  bcd_digit_t cont_0,
    output logic       limp,
    output logic       hab,
    output logic       busy,
    output bcd_digit_t disp_3,
    output bcd_digit_t disp_2,
    output bcd_digit_t disp_1,
    output bcd_digit_t disp_0,
    output logic       meas_valid,
    output logic       ovf,
    output logic       bcd_err
);

    // Timer must hold GATE_CYCLES-1 and the 4-bit clear/settle reloads.
    localparam int TW = ($clog2(GATE_CYCLES) > 4) ? $clog2(GATE_CYCLES) : 4;

    localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    meas_state_t     r_state;
    meas_state_t     w_next_state;
    logic            w_load;
    logic [TW-1:0]   w_load_val;
    logic            w_timer_en;
    logic            w_timer_zero;

    logic            w_limp_d;
    logic            w_hab_d;
    logic            w_busy_d;
    logic            w_capture;
    logic            w_ovf_d;
    logic            w_err_d;

    phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clk      (clk),
        .RESET    (RESET),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_timer_en),
        .zero     (w_timer_zero)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and timer control. start/auto_run are only looked at in
    // IDLE and LATCH, so changes mid-measurement have no effect.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = CLR_LOAD;
        w_timer_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start || auto_run) begin
                    w_load       = 1'b1;
                    w_load_val   = CLR_LOAD;
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                w_timer_en = 1'b1;
                if (w_timer_zero) begin
                    w_load       = 1'b1;
                    w_load_val   = GATE_LOAD;
                    w_next_state = GATE;
                end
            end
            GATE: begin
                w_timer_en = 1'b1;
                if (w_timer_zero) begin
                    w_load       = 1'b1;
                    w_load_val   = SETTLE_LOAD;
                    w_next_state = SETTLE;
                end
            end
            SETTLE: begin
                w_timer_en = 1'b1;
                if (w_timer_zero) begin
                    w_next_state = LATCH;
                end
            end
            LATCH: begin
                if (auto_run) begin
                    w_load       = 1'b1;
                    w_load_val   = CLR_LOAD;
                    w_next_state = CLEAR;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (next values of the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        w_limp_d  = (r_state == CLEAR);
        w_hab_d   = (r_state == GATE);
        w_busy_d  = (r_state != IDLE);
        w_capture = (r_state == LATCH);
        w_ovf_d   = ({cont_3, cont_2, cont_1, cont_0} == BCD_FULL);
        w_err_d   = digit_bad(cont_3) | digit_bad(cont_2) |
                    digit_bad(cont_1) | digit_bad(cont_0);
    end

    // ------------------------------------------------------------------
    // Output registers. Result and flags only change on a capture, so they
    // hold across the following CLEAR/GATE/SETTLE phases.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RESET) begin
            limp       <= 1'b0;
            hab        <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            ovf        <= 1'b0;
            bcd_err    <= 1'b0;
            disp_3     <= '0;
            disp_2     <= '0;
            disp_1     <= '0;
            disp_0     <= '0;
        end else begin
            limp       <= w_limp_d;
            hab        <= w_hab_d;
            busy       <= w_busy_d;
            meas_valid <= w_capture;
            if (w_capture) begin
                disp_3  <= cont_3;
                disp_2  <= cont_2;
                disp_1  <= cont_1;
                disp_0  <= cont_0;
                ovf     <= w_ovf_d;
                bcd_err <= w_err_d;
            end
        end
    end

endmodule
`default_nettype wire
